// File: rtl/lsu_data_memory.sv
// Load/store data memory with valid/ready request and response handshakes.
// Handles RV32 byte/half/word accesses and reports misaligned, out-of-range and illegal-size requests.
module lsu_data_memory #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic            i_req_write,
  input  logic [2:0]      i_req_funct3,
  input  logic [XLEN-1:0] i_req_addr,
  input  logic [XLEN-1:0] i_req_wdata,
  output logic            o_resp_valid,
  input  logic            i_resp_ready,
  output logic [XLEN-1:0] o_resp_rdata,
  output logic            o_resp_error,
  output logic            o_busy
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_next;
  logic [XLEN-1:0] r_mem [DEPTH_WORDS];
  logic [XLEN-1:0] r_hold_data;
  logic            r_hold_error;
  logic            r_req_ready;
  logic            r_resp_valid;
  logic [XLEN-1:0] r_resp_rdata;
  logic            r_resp_error;
  logic            r_busy;

  logic            w_accept;
  logic [AW-1:0]   w_idx;
  logic [1:0]      w_lane;
  logic            w_oor;
  logic            w_f3_bad;
  logic            w_misalign;
  logic            w_error;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_word;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_ext;
  logic [XLEN-1:0] w_load_value;
  logic [XLEN-1:0] w_resp_src_data;
  logic            w_resp_src_error;

  assign w_accept = i_req_valid & r_req_ready;
  assign w_idx    = i_req_addr[AW+1:2];
  assign w_lane   = i_req_addr[1:0];
  assign w_oor    = (i_req_addr >> (AW + 2)) != {XLEN{1'b0}};
  assign w_word   = r_mem[w_idx];
  assign w_half   = w_lane[1] ? w_word[31:16] : w_word[15:0];

  // Byte selection for sub-word loads
  always_comb begin
    w_byte = 8'h00;
    case (w_lane)
      2'd0:    w_byte = w_word[7:0];
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      2'd3:    w_byte = w_word[31:24];
      default: w_byte = 8'h00;
    endcase
  end

  // Request decode: size/sign, alignment, byte enables and lane-replicated store data
  always_comb begin
    w_f3_bad   = 1'b0;
    w_misalign = 1'b0;
    w_be       = 4'b0000;
    w_wdata    = i_req_wdata;
    w_ext      = {XLEN{1'b0}};
    case (i_req_funct3)
      3'b000: begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{i_req_wdata[7:0]}};
        w_ext   = {{(XLEN-8){w_byte[7]}}, w_byte};
      end
      3'b001: begin
        w_misalign = w_lane[0];
        w_be       = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata    = {2{i_req_wdata[15:0]}};
        w_ext      = {{(XLEN-16){w_half[15]}}, w_half};
      end
      3'b010: begin
        w_misalign = (w_lane != 2'd0);
        w_be       = 4'b1111;
        w_ext      = w_word;
      end
      3'b100: begin
        if (i_req_write) begin
          w_f3_bad = 1'b1;
        end else begin
          w_ext = {{(XLEN-8){1'b0}}, w_byte};
        end
      end
      3'b101: begin
        w_misalign = w_lane[0];
        if (i_req_write) begin
          w_f3_bad = 1'b1;
        end else begin
          w_ext = {{(XLEN-16){1'b0}}, w_half};
        end
      end
      default: w_f3_bad = 1'b1;
    endcase
  end

  assign w_error      = w_f3_bad | w_misalign | w_oor;
  assign w_load_value = (i_req_write | w_error) ? {XLEN{1'b0}} : w_ext;

  // Store commit at the accepting edge; memory is deliberately not reset
  always_ff @(posedge clk) begin
    if (w_accept && i_req_write && !w_error) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
        end
      end
    end
  end

  // Next-state and latency counter logic
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (i_req_valid) begin
          if (LATENCY == 1) begin
            w_state_next = S_RESP;
          end else begin
            w_state_next = S_WAIT;
            w_cnt_next   = CW'(LATENCY - 2);
          end
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_cnt == {CW{1'b0}}) begin
          w_state_next = S_RESP;
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      S_RESP: begin
        if (i_resp_ready) begin
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_RESP;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // With LATENCY == 1 the response is loaded straight from the decode path
  assign w_resp_src_data  = (r_state == S_IDLE) ? w_load_value : r_hold_data;
  assign w_resp_src_error = (r_state == S_IDLE) ? w_error : r_hold_error;

  // State, holding register and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= {CW{1'b0}};
      r_hold_data  <= {XLEN{1'b0}};
      r_hold_error <= 1'b0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= {XLEN{1'b0}};
      r_resp_error <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_req_ready  <= (w_state_next == S_IDLE);
      r_resp_valid <= (w_state_next == S_RESP);
      r_busy       <= (w_state_next != S_IDLE);
      if (w_accept) begin
        r_hold_data  <= w_load_value;
        r_hold_error <= w_error;
      end else begin
        r_hold_data  <= r_hold_data;
        r_hold_error <= r_hold_error;
      end
      if ((r_state != S_RESP) && (w_state_next == S_RESP)) begin
        r_resp_rdata <= w_resp_src_data;
        r_resp_error <= w_resp_src_error;
      end else if ((r_state == S_RESP) && i_resp_ready) begin
        r_resp_rdata <= {XLEN{1'b0}};
        r_resp_error <= 1'b0;
      end else begin
        r_resp_rdata <= r_resp_rdata;
        r_resp_error <= r_resp_error;
      end
    end
  end

  assign o_req_ready  = r_req_ready;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_error = r_resp_error;
  assign o_busy       = r_busy;

endmodule

// File: doc/lsu_data_memory.md
Name: lsu_data_memory

Overview:
- Parametrised successor to the single-cycle word data memory: a load/store memory block with valid/ready request and response handshakes and configurable access latency.
- Supports RV32 byte, halfword and word accesses, with sign or zero extension on loads.
- Flags misaligned and out-of-range accesses instead of silently aliasing them.
- Sits between the ALU address path and the writeback mux. Allows one outstanding transaction.

Parameters:
- XLEN, 32, data and address width.
- DEPTH_WORDS, 256, number of XLEN-bit words. Power of two, at least 2.
- LATENCY, 1, cycles from request acceptance to resp_valid. Must be 1 or more.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32 funct3 size/sign code.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data, taken from the low-order bytes.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  XLEN  load result after extension; 0 for stores and errors.
- resp_error  out  1  misaligned, out-of-range or illegal funct3.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (async): state = IDLE; resp_valid = 0, resp_rdata = 0, resp_error = 0, busy = 0, latency counter = 0. Memory contents are not cleared.
- FSM states:
  - IDLE: req_ready = 1. On req_valid go to WAIT; if LATENCY == 1 go directly to RESP.
  - WAIT: count down LATENCY-1 cycles, then go to RESP.
  - RESP: resp_valid = 1. Stay until resp_ready = 1, then go to IDLE.
- req_ready is 1 only in IDLE. The next request is never accepted in the same cycle that a response is consumed.
- Acceptance happens on the rising edge where req_valid and req_ready are both 1. On that edge the block:
  - decodes the request;
  - commits the store;
  - captures the load word into a holding register.
- resp_valid rises exactly LATENCY cycles after the accepting edge.
- resp_rdata and resp_error are stable while resp_valid = 1. They return to 0 on the edge where the response is consumed.
- Word index = req_addr[log2(DEPTH_WORDS)+1:2]. Byte lane = req_addr[1:0].
- Out-of-range: any set bit in req_addr above bit log2(DEPTH_WORDS)+1 raises resp_error.
- Loads:
  - 000 LB: sign-extend the selected byte.
  - 001 LH: sign-extend the selected halfword.
  - 010 LW: full word.
  - 100 LBU: zero-extend the selected byte.
  - 101 LHU: zero-extend the selected halfword.
  - Any other funct3: error.
- Stores:
  - 000 SB: write one lane.
  - 001 SH: write two lanes.
  - 010 SW: write all four lanes.
  - Any other funct3: error.
  - Unwritten lanes keep their value (byte-enable write).
- Alignment:
  - LH, LHU and SH require addr[0] = 0.
  - LW and SW require addr[1:0] = 0.
  - Violation raises resp_error.
- On any error: no memory write, resp_rdata = 0, and the full handshake still completes.
- Read-after-write: a load accepted after a store to the same word returns the stored data, because the store commits at its own accepting edge.
- Reset mid-transaction abandons the response; no response is produced after reset. A store whose accepting edge preceded reset remains committed.
- req_* inputs are ignored outside IDLE.

Test Plan:
- SW 0x11223344 to 0x10, then LW 0x10 (LATENCY = 1) -> resp_valid 1 cycle after accept; rdata = 0x11223344; error = 0.
- SB 0xAB to 0x11 over word 0x11223344, then LW 0x10 -> 0x1122AB44. LB 0x11 -> 0xFFFFFFAB. LBU 0x11 -> 0x000000AB.
- LW 0x12 and SH 0x13 -> resp_error = 1, rdata = 0. The word at 0x10 is unchanged.
- LATENCY = 4, resp_ready held low 3 cycles -> resp_valid at accept+4 and held stable; req_ready = 0 throughout; returns to IDLE the cycle after resp_ready = 1.
- DEPTH_WORDS = 256, LW 0x400 -> resp_error = 1. funct3 = 011 load -> resp_error = 1.
- Store accepted, reset asserted during WAIT -> resp_valid stays 0. After reset, LW to the same address returns the stored value.
